// File: rtl/video_fetch_if.sv
// Display-fetch bus: line timing and mode controls in, VRAM and
// character-generator ports, and the pixel stream out.
interface video_fetch_if #(
   parameter int ADDR_WIDTH = 13
);
   logic [1:0]            mode;
   logic [5:0]            width;
   logic                  hsn;
   logic                  fsn;
   logic                  preload;
   logic [1:0]            active;
   logic [ADDR_WIDTH-1:0] vram_addr;
   logic [7:0]            vram_data;
   logic [6:0]            char_code;
   logic [3:0]            char_row;
   logic [7:0]            glyph_data;
   logic [1:0]            pixel;
   logic                  pixel_valid;

   // Fetch engine side.
   modport master (
      input  mode, width, hsn, fsn, preload, active, vram_data, glyph_data,
      output vram_addr, char_code, char_row, pixel, pixel_valid
   );

   // Timing generator / memory side.
   modport slave (
      output mode, width, hsn, fsn, preload, active, vram_data, glyph_data,
      input  vram_addr, char_code, char_row, pixel, pixel_valid
   );
endinterface

// File: rtl/video_fetch.sv
// Per-line VRAM fetch and pixel shifter. A line is primed by the preload
// pulse, then one byte is fetched per byte period while the previous byte is
// shifted out. Text mode goes through the character generator (char_code ->
// glyph_data) and walks 12 glyph rows per character row.
module video_fetch #(
   parameter int                    ADDR_WIDTH = 13,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 13'h0400
) (
   input logic           clk,
   input logic           reset,
   video_fetch_if.master bus
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TEXT_STEP = ADDR_WIDTH'(32);

   typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

   state_t                state;
   logic [1:0]            lineMode;     // 0 text, 1 1bpp, 2 2bpp (held for the line)
   logic [5:0]            lineWidth;    // 8, 16 or 32 (held for the line)
   logic [ADDR_WIDTH-1:0] rowBase;
   logic [ADDR_WIDTH-1:0] lineAddr;
   logic [ADDR_WIDTH-1:0] vramAddr;
   logic [6:0]            charCode;
   logic [3:0]            charRow;
   logic [7:0]            dataBuf;
   logic [7:0]            shifter;
   logic [5:0]            byteCnt;
   logic [4:0]            byteTimer;
   logic                  fetchData;    // vram_data is due this clock
   logic                  fetchGlyph;   // glyph_data is due this clock
   logic                  hsnReg;
   logic                  reachedRun;

   logic [1:0]            modeNorm;
   logic [5:0]            widthNorm;
   logic [4:0]            cpbLast;
   logic [4:0]            bpMask;
   logic                  lineText;
   logic                  line2bpp;
   logic                  viewport;
   logic                  hsnFall;

   assign lineText = (lineMode == 2'd0);
   assign line2bpp = (lineMode == 2'd2);
   assign viewport = (bus.active == 2'b11);
   assign hsnFall  = hsnReg & ~bus.hsn;

   // Normalise the mode/width inputs before they are captured at preload.
   always_comb begin
      modeNorm  = (bus.mode == 2'b11) ? 2'b01 : bus.mode;
      widthNorm = 6'd32;
      if (bus.mode != 2'b00 && (bus.width == 6'd8 || bus.width == 6'd16))
         widthNorm = bus.width;
   end

   // Clocks per byte minus one, and bit period minus one used as a mask
   // (both periods are powers of two).
   always_comb begin
      case (lineWidth)
         6'd8:    cpbLast = 5'd31;
         6'd16:   cpbLast = 5'd15;
         default: cpbLast = 5'd7;
      endcase
      bpMask = line2bpp ? (cpbLast >> 2) : (cpbLast >> 3);
   end

   // Line state machine, fetch pipeline and row bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         lineMode   <= 2'd1;
         lineWidth  <= 6'd32;
         rowBase    <= BASE_ADDR;
         lineAddr   <= BASE_ADDR;
         vramAddr   <= BASE_ADDR;
         charCode   <= '0;
         charRow    <= '0;
         dataBuf    <= '0;
         shifter    <= '0;
         byteCnt    <= '0;
         byteTimer  <= '0;
         fetchData  <= 1'b0;
         fetchGlyph <= 1'b0;
         hsnReg     <= 1'b1;
         reachedRun <= 1'b0;
      end else begin
         hsnReg     <= bus.hsn;
         fetchData  <= 1'b0;
         fetchGlyph <= 1'b0;

         // Fetch pipeline: data one clock after the address, glyph one more.
         if (fetchData) begin
            if (lineText) begin
               charCode   <= bus.vram_data[6:0];
               fetchGlyph <= 1'b1;
            end else begin
               dataBuf <= bus.vram_data;
            end
         end
         if (fetchGlyph)
            dataBuf <= bus.glyph_data;

         if (!bus.fsn) begin
            // Frame restart overrides everything else.
            state      <= IDLE;
            rowBase    <= BASE_ADDR;
            lineAddr   <= BASE_ADDR;
            vramAddr   <= BASE_ADDR;
            charRow    <= '0;
            reachedRun <= 1'b0;
            fetchData  <= 1'b0;
            fetchGlyph <= 1'b0;
         end else if (hsnFall) begin
            // End of line: advance the row only if the line was displayed.
            if (reachedRun) begin
               if (lineText) begin
                  if (charRow == 4'd11) begin
                     charRow  <= '0;
                     rowBase  <= rowBase + TEXT_STEP;
                     lineAddr <= rowBase + TEXT_STEP;
                  end else begin
                     charRow  <= charRow + 4'd1;
                     lineAddr <= rowBase;
                  end
               end else begin
                  rowBase  <= rowBase + ADDR_WIDTH'(lineWidth);
                  lineAddr <= rowBase + ADDR_WIDTH'(lineWidth);
               end
            end else begin
               lineAddr <= rowBase;
            end
            reachedRun <= 1'b0;
            state      <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.preload) begin
                     lineMode  <= modeNorm;
                     lineWidth <= widthNorm;
                     vramAddr  <= lineAddr;
                     fetchData <= 1'b1;
                     state     <= PRIME;
                  end
               end
               PRIME: begin
                  if (viewport) begin
                     shifter    <= dataBuf;
                     lineAddr   <= lineAddr + ADDR_ONE;
                     vramAddr   <= lineAddr + ADDR_ONE;
                     fetchData  <= 1'b1;
                     byteCnt    <= 6'd1;
                     byteTimer  <= cpbLast;
                     reachedRun <= 1'b1;
                     state      <= RUN;
                  end
               end
               RUN: begin
                  if (!viewport) begin
                     state <= DONE;
                  end else if (byteTimer == 5'd0) begin
                     if (byteCnt == lineWidth) begin
                        state <= DONE;
                     end else begin
                        shifter   <= dataBuf;
                        lineAddr  <= lineAddr + ADDR_ONE;
                        byteCnt   <= byteCnt + 6'd1;
                        byteTimer <= cpbLast;
                        // The byte after this one, unless the line is complete.
                        if ((byteCnt + 6'd1) < lineWidth) begin
                           vramAddr  <= lineAddr + ADDR_ONE;
                           fetchData <= 1'b1;
                        end
                     end
                  end else begin
                     byteTimer <= byteTimer - 5'd1;
                     if ((byteTimer & bpMask) == 5'd0)
                        shifter <= line2bpp ? {shifter[5:0], 2'b00}
                                            : {shifter[6:0], 1'b0};
                  end
               end
               default: ;   // DONE waits for the hsn edge
            endcase
         end
      end
   end

   // Pixel stream is only meaningful in the viewport while running.
   always_comb begin
      bus.pixel       = 2'b00;
      bus.pixel_valid = 1'b0;
      if (state == RUN && viewport) begin
         bus.pixel_valid = 1'b1;
         bus.pixel       = line2bpp ? shifter[7:6] : {1'b0, shifter[7]};
      end
   end

   assign bus.vram_addr = vramAddr;
   assign bus.char_code = charCode;
   assign bus.char_row  = charRow;

endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch: a table of single-line scenarios plus
// hand-written sequences for text rows, frame restart and reset.
module tb_video_fetch;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   video_fetch_if #(.ADDR_WIDTH(13)) bus ();

   video_fetch #(.ADDR_WIDTH(13), .BASE_ADDR(13'h0400)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // VRAM read data follows the address presented on the previous clock;
   // glyph ROM answers for the current char_code/char_row.
   logic [7:0] mem [0:8191];
   assign bus.vram_data  = mem[bus.vram_addr];
   assign bus.glyph_data = (bus.char_code == 7'h41) ? 8'h3C
                                                    : {bus.char_code[3:0], bus.char_row};

   int total = 0;
   int bad   = 0;

   int          nValid;
   int          steps;
   int          badSteps;
   int          stray;
   bit          rec;
   logic [12:0] prevAddr;
   logic [1:0]  pixLog [0:511];

   typedef struct {
      logic [1:0]  mode;
      logic [5:0]  width;
      logic [7:0]  byte0;
      int          bp;
      int          npix;
      logic [15:0] expPix;
      logic [12:0] expLast;
      int          expSteps;
      logic [12:0] expNext;
      bit          midPreload;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end else begin
         $display("check %s: %0h", name, got);
      end
   endtask

   // One clock: sample at the falling edge, then let the rising edge act.
   task automatic cyc();
      @(negedge clk);
      if (rec) begin
         if (bus.pixel_valid) begin
            if (nValid < 512) pixLog[nValid] = bus.pixel;
            nValid++;
         end else if (bus.pixel != 2'b00) begin
            stray++;
         end
         if (bus.vram_addr != prevAddr) begin
            if (bus.vram_addr == prevAddr + 13'd1) steps++;
            else badSteps++;
            prevAddr = bus.vram_addr;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fsnPulse();
      bus.fsn = 1'b0; cyc();
      bus.fsn = 1'b1; cyc();
   endtask

   // Preload, 8 clocks later open the viewport for a full line, then hsn.
   task automatic runLine(input logic [1:0] m, input logic [5:0] w,
                          input logic [12:0] start, input bit midPre);
      rec = 1'b1; nValid = 0; steps = 0; badSteps = 0; stray = 0;
      prevAddr = start;
      bus.mode = m; bus.width = w;
      bus.preload = 1'b1; cyc(); bus.preload = 1'b0;
      repeat (7) cyc();
      bus.active = 2'b11;
      for (int i = 0; i < 262; i++) begin
         bus.preload = midPre && (i == 100);
         cyc();
      end
      bus.preload = 1'b0;
      bus.active = 2'b10; repeat (4) cyc();
      bus.active = 2'b00;
      bus.hsn = 1'b0; cyc(); cyc();
      bus.hsn = 1'b1; cyc();
      rec = 1'b0;
   endtask

   function automatic logic [15:0] packPix(input int bp, input int npix);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < npix; k++) r[15-2*k -: 2] = pixLog[k*bp];
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h5A;
      bus.mode = 2'b01; bus.width = 6'd32; bus.hsn = 1'b1; bus.fsn = 1'b1;
      bus.preload = 1'b0; bus.active = 2'b00;
      rec = 1'b0; nValid = 0; steps = 0; badSteps = 0; stray = 0; prevAddr = '0;

      //          mode   width  byte   bp npix expPix    last     steps next     midPre
      vecs[0] = '{2'b01, 6'd32, 8'hA5, 1, 8, 16'h4411, 13'h41F, 31, 13'h420, 1'b0};
      vecs[1] = '{2'b10, 6'd16, 8'h1B, 4, 4, 16'h1B00, 13'h40F, 15, 13'h410, 1'b0};
      vecs[2] = '{2'b01, 6'd8,  8'hF0, 4, 8, 16'h5500, 13'h407, 7,  13'h408, 1'b0};
      vecs[3] = '{2'b11, 6'd16, 8'h3C, 2, 8, 16'h0550, 13'h40F, 15, 13'h410, 1'b0};
      vecs[4] = '{2'b01, 6'd20, 8'hA5, 1, 8, 16'h4411, 13'h41F, 31, 13'h420, 1'b1};
      vecs[5] = '{2'b00, 6'd8,  8'h41, 1, 8, 16'h0550, 13'h41F, 31, 13'h400, 1'b0};
      vecs[6] = '{2'b10, 6'd32, 8'hE4, 2, 4, 16'hE400, 13'h41F, 31, 13'h420, 1'b0};

      // Reset state.
      @(posedge clk); #1;
      repeat (3) cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_vram_addr", 32'(bus.vram_addr), 32'h400);
      chk("reset_char", {21'd0, bus.char_code, bus.char_row}, 32'h0);
      chk("reset_pixel", {29'd0, bus.pixel_valid, bus.pixel}, 32'h0);
      @(posedge clk); #1;

      // Table-driven single lines.
      for (int v = 0; v < 7; v++) begin
         fsnPulse();
         mem[13'h400] = vecs[v].byte0;
         runLine(vecs[v].mode, vecs[v].width, 13'h400, vecs[v].midPreload);
         chk($sformatf("v%0d_pixels", v), 32'(packPix(vecs[v].bp, vecs[v].npix)), 32'(vecs[v].expPix));
         chk($sformatf("v%0d_valid_clocks", v), 32'(nValid), 32'd256);
         chk($sformatf("v%0d_addr_steps", v), 32'(steps), 32'(vecs[v].expSteps));
         chk($sformatf("v%0d_bad_steps_stray", v), 32'(badSteps + stray), 32'd0);
         chk($sformatf("v%0d_last_addr", v), 32'(prevAddr), 32'(vecs[v].expLast));
         bus.preload = 1'b1; cyc(); bus.preload = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_next_line_addr", v), 32'(bus.vram_addr), 32'(vecs[v].expNext));
         @(posedge clk); #1;
      end

      // Text: char_code one clock after the address; aborted line keeps the row.
      fsnPulse();
      mem[13'h400] = 8'h41;
      bus.mode = 2'b00; bus.width = 6'd32;
      bus.preload = 1'b1; cyc(); bus.preload = 1'b0;
      @(negedge clk);
      chk("text_prime_addr", 32'(bus.vram_addr), 32'h400);
      @(posedge clk); #1;
      @(negedge clk);
      chk("text_char_code", 32'(bus.char_code), 32'h41);
      @(posedge clk); #1;
      repeat (3) cyc();
      bus.hsn = 1'b0; cyc(); cyc(); bus.hsn = 1'b1; cyc();
      @(negedge clk);
      chk("text_unrun_row", 32'(bus.char_row), 32'd0);
      @(posedge clk); #1;
      bus.preload = 1'b1; cyc(); bus.preload = 1'b0;
      @(negedge clk);
      chk("text_unrun_base", 32'(bus.vram_addr), 32'h400);
      @(posedge clk); #1;
      bus.hsn = 1'b0; cyc(); bus.hsn = 1'b1; cyc();

      // Twelve glyph rows, then the character row advances by 32.
      for (int i = 0; i < 12; i++) begin
         runLine(2'b00, 6'd32, 13'h400, 1'b0);
         @(negedge clk);
         chk($sformatf("text_row_%0d", i), 32'(bus.char_row), 32'((i + 1) % 12));
         @(posedge clk); #1;
      end
      bus.preload = 1'b1; cyc(); bus.preload = 1'b0;
      @(negedge clk);
      chk("text_row_base_after_12", 32'(bus.vram_addr), 32'h420);
      @(posedge clk); #1;

      // fsn in the middle of a running line.
      fsnPulse();
      runLine(2'b00, 6'd32, 13'h400, 1'b0);
      bus.mode = 2'b00;
      bus.preload = 1'b1; cyc(); bus.preload = 1'b0;
      repeat (7) cyc();
      bus.active = 2'b11;
      repeat (40) cyc();
      @(negedge clk);
      chk("fsn_pre_valid", 32'(bus.pixel_valid), 32'd1);
      @(posedge clk); #1;
      bus.fsn = 1'b0; cyc(); bus.fsn = 1'b1;
      @(negedge clk);
      chk("fsn_valid", 32'(bus.pixel_valid), 32'd0);
      chk("fsn_vram_addr", 32'(bus.vram_addr), 32'h400);
      chk("fsn_char_row", 32'(bus.char_row), 32'd0);
      @(posedge clk); #1;
      bus.active = 2'b00;
      cyc();

      // Reset in the middle of a running text line.
      runLine(2'b00, 6'd32, 13'h400, 1'b0);
      bus.preload = 1'b1; cyc(); bus.preload = 1'b0;
      repeat (7) cyc();
      bus.active = 2'b11;
      repeat (50) cyc();
      reset = 1'b1; cyc(); reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_vram_addr", 32'(bus.vram_addr), 32'h400);
      chk("rst_mid_char", {21'd0, bus.char_code, bus.char_row}, 32'h0);
      chk("rst_mid_pixel", {29'd0, bus.pixel_valid, bus.pixel}, 32'h0);
      @(posedge clk); #1;
      bus.active = 2'b00;
      cyc();
      mem[13'h400] = 8'hA5;
      runLine(2'b01, 6'd32, 13'h400, 1'b0);
      chk("rst_restart_pixels", 32'(packPix(1, 8)), 32'h4411);
      chk("rst_restart_last", 32'(prevAddr), 32'h41F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
